fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002: Parameter NOP_INSTR, default 32'h0000_0013: ADDI x0,x0,0, the instruction inserted on bubble.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  synchronous, active-low reset.
REQ-005: stall_f  input  1  hazard-unit hold; freezes PC and the IF/ID register.
REQ-006: flush_d  input  1  clears the IF/ID register to a bubble.
REQ-007: pc_src_e  input  1  taken branch/jump resolved in EX.
REQ-008: pc_target_e  input  32  redirect target from EX.
REQ-009: imem_addr  output  32  instruction-memory address; equals the current PC.
REQ-010: imem_rdata  input  32  instruction word; combinational read of imem_addr.
REQ-011: instr_d  output  32  IF/ID instruction.
REQ-012: pc_d  output  32  IF/ID PC.
REQ-013: pc_plus4_d  output  32  IF/ID PC+4.
REQ-014: valid_d  output  1  IF/ID holds a real fetched instruction.
REQ-015: misalign_d  output  1  the PC of the IF/ID instruction came from a misaligned redirect.
REQ-016: fetch_count  output  32  number of instructions loaded into IF/ID since reset.

Function
REQ-017: imem_addr SHALL be driven combinationally from the PC register; no internal memory.
REQ-018: Next-PC priority: pc_src_e -> {pc_target_e[31:2],2'b00}; else stall_f -> hold; else PC+4.
REQ-019: pc_src_e SHALL override stall_f for the PC update.
REQ-020: PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-021: A misalign flag register SHALL be set when a redirect has pc_target_e[1:0]!=0, cleared on any other PC update, and held while the PC holds.
REQ-022: IF/ID priority: flush_d -> bubble; else stall_f -> hold; else load {imem_rdata, PC, PC+4, 1, misalign flag}.
REQ-023: Bubble: instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, misalign_d=0.
REQ-024: flush_d SHALL override stall_f on the IF/ID register.
REQ-025: Latency: the instruction at PC appears on instr_d exactly one clock after PC is presented on imem_addr.
REQ-026: fetch_count SHALL increment by 1 only on an IF/ID load (not on bubble or hold); it wraps at 2^32.
REQ-027: The next-PC and IF/ID paths SHALL be two independent registered stages; no combinational path from imem_rdata to any output.

Reset
REQ-028: On rising clk with rst=0: PC=RESET_PC, misalign flag=0, IF/ID=bubble, fetch_count=0; all other inputs are ignored.
REQ-029: Reset asserted mid-operation SHALL discard pending stall/flush/redirect; the first fetch after release is at RESET_PC.
REQ-030: On the first edge after rst returns to 1, the word at RESET_PC SHALL load into IF/ID (valid_d=1).

Structure
REQ-031: NOP_INSTR, the reset PC default and the instruction width SHALL live in the shared rv_pkg package.
REQ-032: One sub-module, pc_reg (PC register with hold and synchronous reset), is natural; the IF/ID register stays inline.

Verification
REQ-033: Reset -> imem_addr=0, instr_d=32'h13, valid_d=0, fetch_count=0.
REQ-034: mem[0]=32'h00500093, mem[1]=32'h00A00113, no hazards -> cycle 1 instr_d=00500093, pc_d=0, pc_plus4_d=4; cycle 2 instr_d=00A00113, pc_d=4; fetch_count=2.
REQ-035: stall_f=1 for 2 cycles at PC=8 -> imem_addr stays 8, IF/ID and fetch_count unchanged, then resumes at 8.
REQ-036: pc_src_e=1, pc_target_e=32'h40, flush_d=1 together with stall_f=1 -> next imem_addr=32'h40, IF/ID bubble, valid_d=0.
REQ-037: Redirect to 32'h42 -> imem_addr=32'h40; the next IF/ID load has pc_d=32'h40, misalign_d=1; the following load has misalign_d=0.
REQ-038: rst=0 for one cycle while at PC=32'h20 with stall_f=1 -> PC=0, IF/ID bubble, fetch_count=0, then normal fetch from 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: instruction width, default reset PC,
// the canonical NOP and the IF/ID pipeline bundle with its bubble value.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    // ADDI x0,x0,0
    localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            misalign;
    } if_id_t;

    function automatic if_id_t if_id_bubble(
        input logic [ILEN-1:0] nop
    );
        if_id_t b;
        b.instr    = nop;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        b.misalign = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// PC register: redirect > hold > PC+4, with synchronous active-low reset.
// Ports: clk, rst, i_stall, i_redirect, i_target -> o_pc, o_pc_plus4, o_misalign.
module pc_reg
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_misalign
);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;

    // Wraps modulo 2^32 with no flag.
    assign o_pc_plus4 = r_pc + 32'd4;
    assign o_pc       = r_pc;
    assign o_misalign = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (i_redirect) begin
            // Redirect wins over hold; low bits are dropped but remembered.
            r_pc       <= {i_target[XLEN-1:2], 2'b00};
            r_misalign <= |i_target[1:0];
        end else if (!i_stall) begin
            r_pc       <= o_pc_plus4;
            r_misalign <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem_addr from the PC and registers the
// IF/ID bundle. Ports: clk, rst (sync active-low), stall_f, flush_d,
// pc_src_e, pc_target_e, imem_rdata in; imem_addr, instr_d, pc_d,
// pc_plus4_d, valid_d, misalign_d, fetch_count out.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            misalign_d,
    output logic [31:0]     fetch_count
);

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_misalign;

    if_id_t          r_if_id;
    logic [31:0]     r_fetch_count;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_stall    (stall_f),
        .i_redirect (pc_src_e),
        .i_target   (pc_target_e),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4),
        .o_misalign (w_misalign)
    );

    assign imem_addr = w_pc;

    // Flush beats stall; only a real load counts as a fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_id       <= if_id_bubble(NOP_INSTR);
            r_fetch_count <= '0;
        end else if (flush_d) begin
            r_if_id       <= if_id_bubble(NOP_INSTR);
        end else if (!stall_f) begin
            r_if_id.instr    <= imem_rdata;
            r_if_id.pc       <= w_pc;
            r_if_id.pc_plus4 <= w_pc_plus4;
            r_if_id.valid    <= 1'b1;
            r_if_id.misalign <= w_misalign;
            r_fetch_count    <= r_fetch_count + 32'd1;
        end
    end

    assign instr_d     = r_if_id.instr;
    assign pc_d        = r_if_id.pc;
    assign pc_plus4_d  = r_if_id.pc_plus4;
    assign valid_d     = r_if_id.valid;
    assign misalign_d  = r_if_id.misalign;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized hazards checked against a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_d;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the specification says each output must be.
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_misd;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign imem_rdata = word(imem_addr);

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .misalign_d  (misalign_d),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void bubble();
        m_instr = 32'h13;
        m_pcd   = 0;
        m_pc4   = 0;
        m_valid = 0;
        m_misd  = 0;
    endfunction

    // One clock of the architectural rules, from the values seen at the edge.
    function automatic void model_step();
        if (!rst) begin
            m_pc  = 0;
            m_mis = 0;
            m_cnt = 0;
            bubble();
        end else begin
            if (flush_d) begin
                bubble();
            end else if (!stall_f) begin
                m_instr = word(m_pc);
                m_pcd   = m_pc;
                m_pc4   = m_pc + 4;
                m_valid = 1;
                m_misd  = m_mis;
                m_cnt   = m_cnt + 1;
            end
            if (pc_src_e) begin
                m_pc  = pc_target_e & 32'hFFFF_FFFC;
                m_mis = pc_target_e[1:0] != 2'b00;
            end else if (!stall_f) begin
                m_pc  = m_pc + 4;
                m_mis = 0;
            end
        end
    endfunction

    task automatic compare_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_d", instr_d, m_instr);
        chk("pc_d", pc_d, m_pcd);
        chk("pc_plus4_d", pc_plus4_d, m_pc4);
        chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
        chk("misalign_d", {31'b0, misalign_d}, {31'b0, m_misd});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // Advance one clock, update the model, then check on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic b, input logic [31:0] t);
        rst         = r;
        stall_f     = s;
        flush_d     = f;
        pc_src_e    = b;
        pc_target_e = t;
    endtask

    initial begin
        m_pc = 0; m_mis = 0; m_cnt = 0;
        bubble();
        drive(0, 1, 1, 1, 32'h1234_5677);
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);

        drive(1, 0, 0, 0, 0);
        cyc();
        chk("f1_instr", instr_d, 32'h0050_0093);
        chk("f1_pc", pc_d, 32'h0);
        chk("f1_pc4", pc_plus4_d, 32'h4);
        chk("f1_valid", {31'b0, valid_d}, 32'h1);
        cyc();
        chk("f2_instr", instr_d, 32'h00A0_0113);
        chk("f2_pc", pc_d, 32'h4);
        chk("f2_cnt", fetch_count, 32'h2);

        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_pc_d", pc_d, 32'h4);
            chk("stall_cnt", fetch_count, 32'h2);
        end
        drive(1, 0, 0, 0, 0);
        cyc();
        chk("resume_pc_d", pc_d, 32'h8);
        chk("resume_cnt", fetch_count, 32'h3);

        drive(1, 1, 1, 1, 32'h40);
        cyc();
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'b0, valid_d}, 32'h0);
        chk("redir_instr", instr_d, 32'h13);

        drive(1, 0, 0, 1, 32'h42);
        cyc();
        chk("mis_addr", imem_addr, 32'h40);
        drive(1, 0, 0, 0, 0);
        cyc();
        chk("mis_pc_d", pc_d, 32'h40);
        chk("mis_flag", {31'b0, misalign_d}, 32'h1);
        cyc();
        chk("mis_clear", {31'b0, misalign_d}, 32'h0);

        drive(1, 0, 0, 1, 32'h20);
        cyc();
        chk("at20", imem_addr, 32'h20);
        drive(0, 1, 1, 1, 32'h80);
        cyc();
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_valid", {31'b0, valid_d}, 32'h0);
        chk("mrst_cnt", fetch_count, 32'h0);
        drive(1, 0, 0, 0, 0);
        cyc();
        chk("mrst_first_pc", pc_d, 32'h0);
        chk("mrst_first_valid", {31'b0, valid_d}, 32'h1);
        chk("mrst_first_instr", instr_d, 32'h0050_0093);

        drive(1, 0, 0, 1, 32'hFFFF_FFFC);
        cyc();
        drive(1, 0, 0, 0, 0);
        cyc();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", pc_plus4_d, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? $urandom
                                            : $urandom_range(0, 255);
            drive($urandom_range(0, 40) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 6) == 0,
                  t);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
